// File: rtl/svi_multich_pipe_pkg.sv
// Shared types and helpers for svi_multich_pipe: default geometry, stage record,
// count type and the counter saturation limit.
package svi_multich_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 3;
  localparam int unsigned DEF_N_CH  = 2;
  localparam int unsigned DEF_CNT_W = 4;

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } stage_rec_t;

  typedef logic [DEF_CNT_W-1:0] count_t;

  // All-ones value of a w-bit counter, clamped to 32 bits.
  function automatic int unsigned sat_limit(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/svi_multich_pipe_if.sv
// Interface holding all pipeline state: per-channel {valid,data} shift chains and
// beat counters. Counters exist only when SVI_MULTICH_PIPE_CNT_EN is defined.
interface svi_multich_pipe_if
  import svi_multich_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned N_CH  = DEF_N_CH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic                    i_clk,
  input logic                    i_rst,
  input logic                    i_stall,
  input logic [N_CH-1:0]         i_clear,
  input logic [N_CH-1:0]         i_valid,
  input logic [N_CH*WIDTH-1:0]   i_data
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t stage [N_CH][DEPTH];

  // Shift chains: data always advances when not stalled; clear kills only valids.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < int'(N_CH); c++)
        for (int k = 0; k < int'(DEPTH); k++)
          stage[c][k] <= '0;
    end else if (!i_stall) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        stage[c][0].valid <= i_valid[c] & ~i_clear[c];
        stage[c][0].data  <= i_data[c*WIDTH +: WIDTH];
        for (int k = 1; k < int'(DEPTH); k++) begin
          stage[c][k].valid <= stage[c][k-1].valid & ~i_clear[c];
          stage[c][k].data  <= stage[c][k-1].data;
        end
      end
    end
  end

`ifdef SVI_MULTICH_PIPE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_limit(CNT_W));

  logic [CNT_W-1:0] count [N_CH];

  // Saturating count of beats leaving the last stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < int'(N_CH); c++) count[c] <= '0;
    end else if (!i_stall) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        if (i_clear[c])
          count[c] <= '0;
        else if (stage[c][DEPTH-1].valid && (count[c] != CNT_MAX))
          count[c] <= count[c] + CNT_W'(1);
      end
    end
  end
`endif

endinterface

// File: rtl/svi_multich_pipe_tap.sv
// Read-only tap: flattens last-stage valid/data and counters out of the interface.
module svi_multich_pipe_tap #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 4
) (
  svi_multich_pipe_if pif
);

  logic [N_CH-1:0]       valid;
  logic [N_CH*WIDTH-1:0] data;
  logic [N_CH*CNT_W-1:0] count;

  always_comb begin
    valid = '0;
    data  = '0;
    count = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      valid[c]                  = pif.stage[c][DEPTH-1].valid;
      data[c*WIDTH +: WIDTH]    = pif.stage[c][DEPTH-1].data;
`ifdef SVI_MULTICH_PIPE_CNT_EN
      count[c*CNT_W +: CNT_W]   = pif.count[c];
`endif
    end
  end

endmodule

// File: rtl/svi_multich_pipe.sv
// Multi-channel registered pipeline with state held in an interface instance.
// Optional beat counters: define SVI_MULTICH_PIPE_CNT_EN (otherwise o_count = 0).
module svi_multich_pipe
  import svi_multich_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned N_CH  = DEF_N_CH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_CH-1:0]       i_valid,
  input  logic [N_CH*WIDTH-1:0] i_data,
  input  logic                  i_stall,
  input  logic [N_CH-1:0]       i_clear,
  output logic [N_CH-1:0]       o_valid,
  output logic [N_CH*WIDTH-1:0] o_data,
  output logic [N_CH*CNT_W-1:0] o_count
);

  svi_multich_pipe_if #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .N_CH(N_CH), .CNT_W(CNT_W)
  ) u_if (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_stall (i_stall),
    .i_clear (i_clear),
    .i_valid (i_valid),
    .i_data  (i_data)
  );

  svi_multich_pipe_tap #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .N_CH(N_CH), .CNT_W(CNT_W)
  ) u_tap (
    .pif (u_if)
  );

  // Outputs come straight from the tap, no extra register stage.
  assign o_valid = u_tap.valid;
  assign o_data  = u_tap.data;
  assign o_count = u_tap.count;

endmodule
